angle_poll_scheduler: RTL and testbench

- Sequences the shared angle-sensor SPI master across NUM_SENSORS magnetic joint encoders (14-bit, AS5048-style framing).
- Every poll tick, round-robin reads each unmasked sensor as a command frame plus a NOP frame, checks the error flag, and publishes the angle.
- Arbitrates a host raw-SPI request into sensor boundaries.
- Sits between the forearm SPI master core and the angle ss_n pins.

---
 rtl/angle_poll_scheduler.sv | 144 ++++++++++++++
 tb/tb_angle_poll_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/angle_poll_scheduler.sv
// angle_poll_scheduler: round-robin AS5048 angle poller with host raw-frame arbitration; define ANGLE_PARITY_CHECK_EN to add frame parity checking
module angle_poll_scheduler #(
  parameter int NUM_SENSORS = 3,
  parameter int POLL_PERIOD = 50000,
  parameter int CS_GAP_CYCLES = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] sensor_mask,
  output logic                   spi_start,
  output logic [15:0]            spi_tx_data,
  input  logic                   spi_busy,
  input  logic                   spi_done,
  input  logic [15:0]            spi_rx_data,
  output logic [NUM_SENSORS-1:0] angle_ss_n_o,
  input  logic                   host_req,
  input  logic [2:0]             host_sel,
  input  logic [15:0]            host_tx_data,
  output logic                   host_grant,
  output logic                   host_done,
  output logic [15:0]            host_rx_data,
  output logic                   angle_valid,
  output logic [2:0]             angle_idx,
  output logic [13:0]            angle_value,
  output logic [1:0]             angle_status,
  output logic                   round_done,
  output logic [7:0]             overrun_count
);
  typedef enum logic [3:0] {
    IDLE, SELECT, CMD_START, CMD_WAIT, GAP, NOP_START, NOP_WAIT, RESULT, HOST_START, HOST_WAIT
  } state_t;
  state_t state, state_n;
  logic [31:0] cnt, tmr;
  logic [3:0] idx, idx_n;
  logic [2:0] hsel, nxt, sel;
  logic [15:0] htx;
  logic [7:0] avail;
  logic [NUM_SENSORS-1:0] onehot;
  logic pend, host_used, host_ret_sel;
  logic tick, host_go, start_round, timed_out, ss_low, rx_bad, is_cmd, is_nop, is_host;
  for (genvar i = 0; i < 8; i++) begin : g_avail
    if (i < NUM_SENSORS) begin : g_on
      assign avail[i] = !sensor_mask[i] && 4'(i) >= idx;
    end else begin : g_off
      assign avail[i] = 1'b0;
    end
  end
`ifdef ANGLE_PARITY_CHECK_EN
  assign rx_bad = ^spi_rx_data;
`else
  assign rx_bad = 1'b0;
`endif
  assign tick = enable && cnt == 32'(POLL_PERIOD - 1);
  assign host_go = host_req && !host_used;
  assign timed_out = tmr == 32'(TIMEOUT_CYCLES - 1) && !spi_done;
  assign start_round = state == IDLE && state_n == SELECT;
  assign is_cmd = state == CMD_START || state == CMD_WAIT;
  assign is_nop = state == NOP_START || state == NOP_WAIT;
  assign is_host = state == HOST_START || state == HOST_WAIT;
  assign spi_start = !spi_busy && (state == CMD_START || state == NOP_START || state == HOST_START);
  assign ss_low = spi_start || state == CMD_WAIT || state == NOP_WAIT || state == HOST_WAIT;
  assign sel = is_host ? hsel : idx[2:0];
  assign onehot = NUM_SENSORS'(1) << sel;
  assign angle_ss_n_o = ss_low ? ~onehot : '1;
  assign spi_tx_data = is_cmd ? 16'hFFFF : is_nop ? 16'hC000 : is_host ? htx : 16'h0000;
  assign host_grant = is_host;
  assign angle_valid = state == RESULT;
  assign angle_idx = idx[2:0];
  assign round_done = state == SELECT && !host_go && avail == 8'd0;
  always_comb begin
    nxt = 3'd0;
    for (int k = 7; k >= 0; k--) if (avail[k]) nxt = 3'(k);
  end
  always_comb begin
    state_n = state;
    idx_n = idx;
    case (state)
      IDLE: begin
        idx_n = 4'd0;
        state_n = host_go ? HOST_START : (tick || pend) ? SELECT : IDLE;
      end
      SELECT: begin
        state_n = host_go ? HOST_START : avail == 8'd0 ? IDLE : CMD_START;
        idx_n = host_go || avail == 8'd0 ? idx : {1'b0, nxt};
      end
      CMD_START: state_n = spi_busy ? CMD_START : CMD_WAIT;
      CMD_WAIT: state_n = spi_done ? GAP : timed_out ? RESULT : CMD_WAIT;
      GAP: state_n = tmr == 32'(CS_GAP_CYCLES - 1) ? NOP_START : GAP;
      NOP_START: state_n = spi_busy ? NOP_START : NOP_WAIT;
      NOP_WAIT: state_n = spi_done || timed_out ? RESULT : NOP_WAIT;
      RESULT: begin
        state_n = SELECT;
        idx_n = idx + 4'd1;
      end
      HOST_START: state_n = spi_busy ? HOST_START : HOST_WAIT;
      HOST_WAIT: state_n = !(spi_done || timed_out) ? HOST_WAIT : host_ret_sel ? SELECT : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      tmr <= '0;
      idx <= '0;
      pend <= 1'b0;
      overrun_count <= '0;
      host_used <= 1'b0;
      host_ret_sel <= 1'b0;
      hsel <= '0;
      htx <= '0;
      host_done <= 1'b0;
      host_rx_data <= '0;
      angle_value <= '0;
      angle_status <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      tmr <= state_n != state ? '0 : tmr + 32'd1;
      cnt <= !enable || tick ? '0 : cnt + 32'd1;
      if (!enable || start_round) pend <= 1'b0;
      else if (tick && pend) overrun_count <= overrun_count == 8'hFF ? overrun_count : overrun_count + 8'd1;
      else if (tick) pend <= 1'b1;
      if ((state == IDLE || state == SELECT) && state_n == HOST_START) begin
        hsel <= host_sel;
        htx <= host_tx_data;
        host_ret_sel <= state == SELECT;
      end
      if (state == HOST_WAIT && state_n != HOST_WAIT) host_used <= 1'b1;
      else if (state_n != state) host_used <= 1'b0;
      host_done <= state == HOST_WAIT && (spi_done || timed_out);
      if (state == HOST_WAIT && spi_done) host_rx_data <= spi_rx_data;
      else if (state == HOST_WAIT && timed_out) host_rx_data <= 16'hFFFF;
      if (state == NOP_WAIT && spi_done) begin
        angle_status <= rx_bad ? 2'd2 : spi_rx_data[14] ? 2'd1 : 2'd0;
        if (!rx_bad && !spi_rx_data[14]) angle_value <= spi_rx_data[13:0];
      end else if ((state == CMD_WAIT || state == NOP_WAIT) && timed_out) begin
        angle_status <= 2'd3;
      end
    end
  end
endmodule

// File: tb/tb_angle_poll_scheduler.sv
// tb_angle_poll_scheduler: vector-table and scoreboard bench for angle_poll_scheduler
`timescale 1ns/1ps
module tb_angle_poll_scheduler;
  localparam int NS = 3;
  localparam int LAT = 3;
  typedef struct {logic [2:0] idx; logic [13:0] val; logic [1:0] st;} res_t;
  typedef struct {logic [2:0] mask; logic [15:0] r0; logic [15:0] r1; logic [15:0] r2; int n_res; int n_st; logic [13:0] fin;} vec_t;
  logic clock = 1'b0, reset = 1'b1, enable = 1'b0, en2 = 1'b0;
  logic [NS-1:0] sensor_mask = '0;
  logic spi_start, spi_busy, spi_done;
  logic [15:0] spi_tx_data, spi_rx_data, rx_next;
  logic [NS-1:0] angle_ss_n_o;
  logic host_req = 1'b0;
  logic [2:0] host_sel = 3'd0;
  logic [15:0] host_tx_data = 16'h0;
  logic host_grant, host_done, angle_valid, round_done;
  logic [15:0] host_rx_data;
  logic [2:0] angle_idx;
  logic [13:0] angle_value;
  logic [1:0] angle_status;
  logic [7:0] overrun_count;
  logic s2_start, s2_grant, s2_hdone, s2_valid, s2_rdone;
  logic [15:0] s2_tx, s2_hrx;
  logic [NS-1:0] s2_ss;
  logic [2:0] s2_idx;
  logic [13:0] s2_val;
  logic [1:0] s2_st;
  logic [7:0] s2_ovr;
  logic [15:0] rsp [NS];
  logic [NS-1:0] hang = '0;
  int lat;
  int checks = 0, errors = 0;
  int cyc = 0, n_starts = 0, n_res = 0, ss1_cnt = 0, hi_run = 0, to_start = 0, to_end = 0, host_at = -1;
  logic [NS-1:0] host_ss = '1;
  logic [13:0] last_good = '0;
  res_t sb [$];
  res_t e;
  int s;
  logic bad;
  logic [1:0] st;
  angle_poll_scheduler #(.NUM_SENSORS(NS), .POLL_PERIOD(200), .CS_GAP_CYCLES(8), .TIMEOUT_CYCLES(4096)) dut (
    .clock(clock), .reset(reset), .enable(enable), .sensor_mask(sensor_mask),
    .spi_start(spi_start), .spi_tx_data(spi_tx_data), .spi_busy(spi_busy), .spi_done(spi_done),
    .spi_rx_data(spi_rx_data), .angle_ss_n_o(angle_ss_n_o), .host_req(host_req), .host_sel(host_sel),
    .host_tx_data(host_tx_data), .host_grant(host_grant), .host_done(host_done), .host_rx_data(host_rx_data),
    .angle_valid(angle_valid), .angle_idx(angle_idx), .angle_value(angle_value), .angle_status(angle_status),
    .round_done(round_done), .overrun_count(overrun_count)
  );
  angle_poll_scheduler #(.NUM_SENSORS(NS), .POLL_PERIOD(20), .CS_GAP_CYCLES(8), .TIMEOUT_CYCLES(4096)) dut2 (
    .clock(clock), .reset(reset), .enable(en2), .sensor_mask(3'b000),
    .spi_start(s2_start), .spi_tx_data(s2_tx), .spi_busy(1'b1), .spi_done(1'b0),
    .spi_rx_data(16'h0000), .angle_ss_n_o(s2_ss), .host_req(1'b0), .host_sel(3'd0),
    .host_tx_data(16'h0000), .host_grant(s2_grant), .host_done(s2_hdone), .host_rx_data(s2_hrx),
    .angle_valid(s2_valid), .angle_idx(s2_idx), .angle_value(s2_val), .angle_status(s2_st),
    .round_done(s2_rdone), .overrun_count(s2_ovr)
  );
  always #5 clock = ~clock;
  always @(posedge clock) begin
    spi_done <= 1'b0;
    if (reset) begin
      spi_busy <= 1'b0;
      lat <= 0;
    end else if (spi_start) begin
      if (host_grant || low_idx(angle_ss_n_o) < 0 || !hang[low_idx(angle_ss_n_o)]) begin
        spi_busy <= 1'b1;
        lat <= LAT;
        rx_next <= host_grant ? spi_tx_data ^ 16'h5A5A : spi_tx_data == 16'hC000 ? rsp[low_idx(angle_ss_n_o)] : 16'h0000;
      end
    end else if (spi_busy) begin
      if (lat == 0) begin
        spi_done <= 1'b1;
        spi_rx_data <= rx_next;
        spi_busy <= 1'b0;
      end else begin
        lat <= lat - 1;
      end
    end
  end
  function automatic int low_idx(input logic [NS-1:0] ss);
    int r = -1;
    for (int i = NS - 1; i >= 0; i--) if (!ss[i]) r = i;
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask
  task automatic step();
    @(negedge clock);
    #1;
  endtask
  initial forever begin
    @(negedge clock);
    cyc++;
    if (reset) begin
      last_good = '0;
      hi_run = 0;
    end else begin
      if (!angle_ss_n_o[1]) ss1_cnt++;
      chk("ss_onehot", 32'($countones(~angle_ss_n_o) <= 1), 32'd1);
      if (spi_start) begin
        n_starts++;
        s = low_idx(angle_ss_n_o);
        if (host_grant) begin
          host_at = n_res;
          host_ss = angle_ss_n_o;
        end else if (s < 0) begin
          chk("start_ss_low", 32'(angle_ss_n_o), 32'd0);
        end else if (spi_tx_data == 16'hC000) begin
          chk("cs_gap", 32'(hi_run >= 8), 32'd1);
`ifdef ANGLE_PARITY_CHECK_EN
          bad = ^rsp[s];
`else
          bad = 1'b0;
`endif
          st = bad ? 2'd2 : rsp[s][14] ? 2'd1 : 2'd0;
          if (st == 2'd0) last_good = rsp[s][13:0];
          sb.push_back('{3'(s), last_good, st});
        end else if (hang[s]) begin
          sb.push_back('{3'(s), last_good, 2'd3});
          to_start = cyc;
        end
      end
      hi_run = angle_ss_n_o == '1 ? hi_run + 1 : 0;
      if (angle_valid) begin
        n_res++;
        if (sb.size() == 0) begin
          chk("angle_unexpected", {27'd0, angle_idx, angle_status}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("angle_result", {15'd0, angle_idx, angle_value, angle_status}, {15'd0, e.idx, e.val, e.st});
          if (e.st == 2'd3) begin
            to_end = cyc;
            chk("timeout_ss_high", 32'(angle_ss_n_o), 32'(3'b111));
          end
        end
      end
    end
  end
  task automatic run_row(input string name, input vec_t v, input int budget);
    int s0, r0, k1, k;
    sensor_mask = v.mask;
    rsp[0] = v.r0;
    rsp[1] = v.r1;
    rsp[2] = v.r2;
    s0 = n_starts;
    r0 = n_res;
    k1 = ss1_cnt;
    enable = 1'b1;
    k = 0;
    while (!round_done && k < budget) begin
      step();
      k++;
    end
    chk({name, "_round_done"}, 32'(round_done), 32'd1);
    enable = 1'b0;
    repeat (4) step();
    chk({name, "_starts"}, 32'(n_starts - s0), 32'(v.n_st));
    chk({name, "_results"}, 32'(n_res - r0), 32'(v.n_res));
    chk({name, "_value"}, 32'(angle_value), 32'(v.fin));
    chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    if (v.mask[1]) chk({name, "_ss1_never_low"}, 32'(ss1_cnt - k1), 32'd0);
  endtask
  initial begin
    vec_t tbl [6];
    int k, r0, s0;
    tbl[0] = '{3'b000, 16'h1234, 16'h1234, 16'h1234, 3, 6, 14'h1234};
    tbl[1] = '{3'b010, 16'h0111, 16'h0222, 16'h0333, 2, 4, 14'h0333};
    tbl[2] = '{3'b000, 16'h0AAA, 16'h4321, 16'h0BBB, 3, 6, 14'h0BBB};
    tbl[3] = '{3'b111, 16'h0001, 16'h0002, 16'h0003, 0, 0, 14'h0BBB};
    tbl[4] = '{3'b000, 16'h8003, 16'h4005, 16'h0006, 3, 6, 14'h0006};
    tbl[5] = '{3'b101, 16'h0001, 16'h0DEF, 16'h0003, 1, 2, 14'h0DEF};
    rsp[0] = 16'h0;
    rsp[1] = 16'h0;
    rsp[2] = 16'h0;
    repeat (4) step();
    reset = 1'b0;
    step();
    chk("rst_ss_n", 32'(angle_ss_n_o), 32'(3'b111));
    chk("rst_outs", {24'd0, spi_start, host_grant, host_done, angle_valid, round_done, angle_status, 1'b0}, 32'd0);
    chk("rst_data", {2'b0, angle_value, spi_tx_data}, 32'd0);
    chk("rst_cnt", {angle_idx, overrun_count, host_rx_data}, 32'd0);
    for (int i = 0; i < 6; i++) run_row($sformatf("row%0d", i), tbl[i], 1000);
    hang = 3'b001;
    run_row("timeout", '{3'b000, 16'h0, 16'h0777, 16'h0888, 3, 5, 14'h0888}, 6000);
    chk("timeout_len", 32'(to_end - to_start >= 4096 && to_end - to_start <= 4100), 32'd1);
    hang = '0;
    sensor_mask = 3'b000;
    rsp[0] = 16'h0111;
    rsp[1] = 16'h0222;
    rsp[2] = 16'h0333;
    r0 = n_res;
    s0 = n_starts;
    enable = 1'b1;
    k = 0;
    while (!(spi_start && spi_tx_data == 16'hC000 && !angle_ss_n_o[0]) && k < 1000) begin
      step();
      k++;
    end
    chk("host_nop0_seen", 32'(k < 1000), 32'd1);
    host_req = 1'b1;
    host_sel = 3'd2;
    host_tx_data = 16'hABCD;
    k = 0;
    while (!host_done && k < 500) begin
      step();
      k++;
    end
    chk("host_done", 32'(host_done), 32'd1);
    chk("host_rx", 32'(host_rx_data), 32'h0000_F197);
    chk("host_after_result", 32'(host_at - r0), 32'd1);
    chk("host_ss", 32'(host_ss), 32'(3'b011));
    host_req = 1'b0;
    k = 0;
    while (!round_done && k < 1000) begin
      step();
      k++;
    end
    enable = 1'b0;
    repeat (4) step();
    chk("host_round_results", 32'(n_res - r0), 32'd3);
    chk("host_round_starts", 32'(n_starts - s0), 32'd7);
    chk("host_grant_low", 32'(host_grant), 32'd0);
    chk("host_sb_empty", 32'(sb.size()), 32'd0);
    enable = 1'b1;
    k = 0;
    while (!(spi_start && spi_tx_data == 16'hFFFF) && k < 1000) begin
      step();
      k++;
    end
    step();
    chk("midframe_ss_low", 32'(angle_ss_n_o), 32'(3'b110));
    reset = 1'b1;
    enable = 1'b0;
    step();
    chk("midframe_rst_ss", 32'(angle_ss_n_o), 32'(3'b111));
    chk("midframe_rst_idle", {15'd0, spi_start, spi_tx_data}, 32'd0);
    chk("midframe_rst_value", 32'(angle_value), 32'd0);
    reset = 1'b0;
    step();
    en2 = 1'b1;
    k = 0;
    while (s2_ovr != 8'd5 && k < 1000) begin
      step();
      k++;
    end
    chk("overrun_5", 32'(s2_ovr), 32'd5);
    repeat (200) step();
    chk("overrun_15", 32'(s2_ovr), 32'd15);
    repeat (5500) step();
    chk("overrun_sat", 32'(s2_ovr), 32'd255);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
